// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART RX FSM: detects end of frame from rx_flag,
// captures {parity_err, data} into a small FIFO and acknowledges with rx_flag_clr.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rx_flag,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_parity_err,
    output logic                  rx_flag_clr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_parity_err,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    // state   | meaning
    // S_WAIT  | idle, waiting for rx_flag to rise
    // S_ARMED | frame in STOP, waiting for rx_flag to fall
    // S_WRITE | one cycle: push captured entry, pulse rx_flag_clr
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ARMED = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [DATA_WIDTH:0]   head;

    logic in_write;
    logic wr_en;
    logic pop;
    logic drop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (rx_flag)  state_d = S_ARMED;
            S_ARMED: if (!rx_flag) state_d = S_WRITE;
            S_WRITE: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        in_write    = (state_q == S_WRITE);
        rx_flag_clr = in_write;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en = in_write && (!full || rd_en);
    assign drop  = in_write && full && !rd_en;

    // Keep sampling the datapath while ARMED so the last copy is the one taken
    // on the edge that sees rx_flag low; rx_data may change during WRITE.
    always_comb begin
        hold_d   = hold_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (state_q == S_ARMED) begin
            hold_d = {rx_parity_err, rx_data};
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= hold_q;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_data       = empty ? '0 : head[DATA_WIDTH-1:0];
    assign rd_parity_err = empty ? 1'b0 : head[DATA_WIDTH];
    assign count         = count_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single frame, fill/overflow,
// full write with pop, parity tagging across wrap, reset during WRITE.
module tb_uart_rx_fifo;

    logic       clk;
    logic       nrst;
    logic       rx_flag;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_flag_clr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_chk = 0;
    int n_bad = 0;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .rx_flag       (rx_flag),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_flag_clr   (rx_flag_clr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx_flag high for 5 edges, then low; clr must be high one cycle after the fall.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic rd);
        rx_data       = d;
        rx_parity_err = p;
        rx_flag       = 1'b1;
        repeat (5) tick();
        chk("clr_before_fall", {31'd0, rx_flag_clr}, 32'd0);
        rx_flag = 1'b0;
        tick();
        chk("clr_pulse_hi", {31'd0, rx_flag_clr}, 32'd1);
        rx_data       = ~d;
        rx_parity_err = ~p;
        rd_en         = rd;
        tick();
        rd_en = 1'b0;
        chk("clr_pulse_lo", {31'd0, rx_flag_clr}, 32'd0);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       saw_clr;
        logic [7:0] exp_q [$];
        logic [7:0] d;
        logic       p;

        nrst          = 1'b0;
        rx_flag       = 1'b0;
        rx_data       = 8'h00;
        rx_parity_err = 1'b0;
        rd_en         = 1'b0;
        ovf_clr       = 1'b0;

        // Reset and idle
        repeat (3) tick();
        chk("rst_count", {28'd0, count}, 32'd0);
        nrst = 1'b1;
        tick();
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_rd_par", {31'd0, rd_parity_err}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        saw_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_flag_clr) saw_clr = 1'b1;
            tick();
        end
        chk("idle_no_clr", {31'd0, saw_clr}, 32'd0);

        // Single frame
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("single_data", {24'd0, rd_data}, 32'hA5);
        chk("single_count", {28'd0, count}, 32'd1);
        chk("single_par", {31'd0, rd_parity_err}, 32'd0);
        chk("single_empty", {31'd0, empty}, 32'd0);
        pop_one();
        chk("single_pop_empty", {31'd0, empty}, 32'd1);
        chk("single_pop_data", {24'd0, rd_data}, 32'd0);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {28'd0, count}, 32'd8);
        send_frame(8'h09, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_head", {24'd0, rd_data}, 32'h01);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", {24'd0, rd_data}, 32'(i));
            pop_one();
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Write into full FIFO with simultaneous pop
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("sim_head", {24'd0, rd_data}, 32'h01);
        send_frame(8'h55, 1'b0, 1'b1);
        chk("sim_count", {28'd0, count}, 32'd8);
        chk("sim_ovf", {31'd0, overflow}, 32'd0);
        chk("sim_full", {31'd0, full}, 32'd1);
        for (int i = 2; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h55);
        for (int i = 0; i < 8; i++) begin
            chk("sim_drain", {24'd0, rd_data}, {24'd0, exp_q[i]});
            pop_one();
        end
        chk("sim_empty", {31'd0, empty}, 32'd1);

        // Parity tagging, one entry buffered, pop during each WRITE
        send_frame(8'h30, 1'b1, 1'b0);
        for (int i = 1; i < 12; i++) begin
            d = 8'h30 + 8'(i - 1);
            p = ((i - 1) % 2 == 0);
            chk("wrap_data", {24'd0, rd_data}, {24'd0, d});
            chk("wrap_par", {31'd0, rd_parity_err}, {31'd0, p});
            send_frame(8'h30 + 8'(i), (i % 2 == 0), 1'b1);
            chk("wrap_count", {28'd0, count}, 32'd1);
        end
        chk("wrap_last_data", {24'd0, rd_data}, 32'h3B);
        chk("wrap_last_par", {31'd0, rd_parity_err}, 32'd0);
        pop_one();
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // rx_flag stuck high: nothing written, then the fall is captured
        rx_data = 8'h7E;
        rx_parity_err = 1'b1;
        rx_flag = 1'b1;
        saw_clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rx_flag_clr) saw_clr = 1'b1;
        end
        chk("stuck_no_clr", {31'd0, saw_clr}, 32'd0);
        chk("stuck_count", {28'd0, count}, 32'd0);
        rx_flag = 1'b0;
        repeat (2) tick();
        chk("stuck_release_data", {24'd0, rd_data}, 32'h7E);
        chk("stuck_release_par", {31'd0, rd_parity_err}, 32'd1);
        pop_one();

        // Reset during WRITE with 3 entries stored
        for (int i = 0; i < 3; i++) send_frame(8'hE0 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_count", {28'd0, count}, 32'd3);
        rx_data = 8'hAA;
        rx_flag = 1'b1;
        repeat (5) tick();
        rx_flag = 1'b0;
        tick();
        chk("mid_write_clr", {31'd0, rx_flag_clr}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("rst_clr_drop", {31'd0, rx_flag_clr}, 32'd0);
        chk("rst_mid_count", {28'd0, count}, 32'd0);
        chk("rst_mid_empty", {31'd0, empty}, 32'd1);
        tick();
        nrst = 1'b1;
        tick();
        chk("post_rst_count", {28'd0, count}, 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        chk("post_rst_data", {24'd0, rd_data}, 32'hC3);
        chk("post_rst_par", {31'd0, rd_parity_err}, 32'd1);
        chk("post_rst_cnt1", {28'd0, count}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
